// File: rtl/uart_cmd_sequencer.sv
// Parses 5-byte UART command frames (header, ch, value hi/lo, xor checksum)
// into a bank of 16-bit setpoint registers with timeout and error accounting.
module uart_cmd_sequencer #(
  parameter int          NUM_CH         = 4,
  parameter logic [7:0]  HEADER         = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 12000,
  parameter int          CH_W           = $clog2(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           rx_data,
  input  logic                 rx_rdy,
  output logic [16*NUM_CH-1:0] ch_values,
  output logic                 upd_strobe,
  output logic [CH_W-1:0]      upd_ch,
  output logic                 frame_err,
  output logic [7:0]           err_count,
  output logic                 busy
);

  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0]    N_LIM  = 9'(NUM_CH);

  typedef enum logic [2:0] {
    HUNT,
    GET_CH,
    GET_VHI,
    GET_VLO,
    GET_CSUM
  } state_t;

  state_t        state;
  logic          rx_rdy_q;
  logic          accept;
  logic [7:0]    ch_byte;
  logic [7:0]    vhi;
  logic [7:0]    vlo;
  logic [7:0]    csum;
  logic [TW-1:0] tcnt;
  logic [15:0]   bank [NUM_CH];
  logic          frame_ok;
  logic          timeout;
  logic [7:0]    err_inc;

  // Rising edge of the ready level; rx_rdy_q resets high so a level
  // already asserted at reset release is not taken as a new byte.
  assign accept = rx_rdy & ~rx_rdy_q;

  assign frame_ok = (rx_data == csum)
                 && ({1'b0, ch_byte} < N_LIM);

  assign timeout = (state != HUNT)
                && (tcnt == T_LAST)
                && !accept;

  assign err_inc = (err_count == 8'hFF)
                 ? err_count
                 : err_count + 8'd1;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign ch_values[16*g +: 16] = bank[g];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= HUNT;
      rx_rdy_q   <= 1'b1;
      ch_byte    <= '0;
      vhi        <= '0;
      vlo        <= '0;
      csum       <= '0;
      tcnt       <= '0;
      upd_strobe <= 1'b0;
      upd_ch     <= '0;
      frame_err  <= 1'b0;
      err_count  <= '0;
      busy       <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        bank[i] <= '0;
      end
    end else begin
      rx_rdy_q   <= rx_rdy;
      upd_strobe <= 1'b0;
      frame_err  <= 1'b0;

      if (state == HUNT || accept || timeout) begin
        tcnt <= '0;
      end else begin
        tcnt <= tcnt + TW'(1);
      end

      if (timeout) begin
        state     <= HUNT;
        busy      <= 1'b0;
        frame_err <= 1'b1;
        err_count <= err_inc;
      end else if (accept) begin
        unique case (state)
          HUNT: begin
            if (rx_data == HEADER) begin
              state <= GET_CH;
              busy  <= 1'b1;
              csum  <= '0;
            end
          end
          GET_CH: begin
            ch_byte <= rx_data;
            csum    <= rx_data;
            state   <= GET_VHI;
          end
          GET_VHI: begin
            vhi   <= rx_data;
            csum  <= csum ^ rx_data;
            state <= GET_VLO;
          end
          GET_VLO: begin
            vlo   <= rx_data;
            csum  <= csum ^ rx_data;
            state <= GET_CSUM;
          end
          GET_CSUM: begin
            if (frame_ok) begin
              for (int i = 0; i < NUM_CH; i++) begin
                if (ch_byte == 8'(i)) begin
                  bank[i] <= {vhi, vlo};
                end
              end
              upd_ch     <= ch_byte[CH_W-1:0];
              upd_strobe <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              err_count <= err_inc;
            end
            state <= HUNT;
            busy  <= 1'b0;
          end
          default: begin
            state <= HUNT;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Scoreboard bench for uart_cmd_sequencer: frames push expected commits
// or errors; a negedge monitor pops and compares on each output pulse.
module tb_uart_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic [63:0] ch_values;
  logic        upd_strobe;
  logic [1:0]  upd_ch;
  logic        frame_err;
  logic [7:0]  err_count;
  logic        busy;

  uart_cmd_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_rdy     (rx_rdy),
    .ch_values  (ch_values),
    .upd_strobe (upd_strobe),
    .upd_ch     (upd_ch),
    .frame_err  (frame_err),
    .err_count  (err_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_err;
    int          cyc;
    logic [63:0] vals;
    logic [1:0]  ch;
    logic [7:0]  ec;
  } exp_t;

  exp_t        sb [$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [15:0] mbank [4];
  int          merr;
  logic        prev_pulse = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [63:0] pack_bank();
    return {mbank[3], mbank[2], mbank[1], mbank[0]};
  endfunction

  // Output monitor / scoreboard consumer
  always @(negedge clk) begin
    logic pulse;
    exp_t e;
    pulse = upd_strobe | frame_err;
    if (prev_pulse) chk("pulse_len", {63'd0, pulse}, 64'd0);
    if (pulse) begin
      chk("exclusive", {63'd0, upd_strobe & frame_err}, 64'd0);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("kind", {63'd0, frame_err}, {63'd0, e.is_err});
        chk("pulse_cyc", 64'(cyc), 64'(e.cyc));
        chk("err_count", {56'd0, err_count}, {56'd0, e.ec});
        chk("ch_values", ch_values, e.vals);
        if (!e.is_err) chk("upd_ch", {62'd0, upd_ch}, {62'd0, e.ch});
      end
    end
    prev_pulse = pulse;
  end

  task automatic send_byte(input logic [7:0] b, input int hold,
                           input int gap, input logic push_it,
                           input exp_t e, output int acc);
    exp_t x;
    @(negedge clk);
    rx_data = b;
    rx_rdy  = 1'b1;
    acc = cyc + 1;
    if (push_it) begin
      x = e;
      x.cyc = acc;
      sb.push_back(x);
    end
    repeat (hold) @(negedge clk);
    rx_rdy = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] h,
                            input logic [7:0] l, input logic [7:0] s,
                            input int hold, input int gap);
    exp_t e;
    int   acc;
    logic ok;
    ok = (s == (c ^ h ^ l)) && (c < 8'd4);
    if (ok) mbank[c[1:0]] = {h, l};
    else if (merr < 255) merr++;
    e.is_err = !ok;
    e.cyc    = 0;
    e.vals   = pack_bank();
    e.ch     = c[1:0];
    e.ec     = 8'(merr);
    send_byte(8'hA5, hold, gap, 1'b0, e, acc);
    send_byte(c, hold, gap, 1'b0, e, acc);
    send_byte(h, hold, gap, 1'b0, e, acc);
    send_byte(l, hold, gap, 1'b0, e, acc);
    send_byte(s, hold, gap, 1'b1, e, acc);
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    exp_t e;
    int   acc;
    for (int i = 0; i < 4; i++) mbank[i] = 16'h0;
    merr    = 0;
    e.is_err = 1'b0; e.cyc = 0; e.vals = '0; e.ch = '0; e.ec = '0;

    // 1: reset with ready held high through release
    reset   = 1'b0;
    rx_rdy  = 1'b1;
    rx_data = 8'hA5;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_vals", ch_values, 64'd0);
    chk("rst_updch", {62'd0, upd_ch}, 64'd0);
    chk("rst_errc", {56'd0, err_count}, 64'd0);
    chk("rst_pulses", {62'd0, upd_strobe, frame_err}, 64'd0);
    rx_rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_idle_busy", {63'd0, busy}, 64'd0);

    // 2: basic commit, slow byte timing with long ready level
    send_frame(8'h02, 8'h12, 8'h34, 8'h24, 220, 1980);
    drain("drain_t2", 50);
    chk("t2_ch2", {48'd0, ch_values[47:32]}, 64'h1234);

    // 3: bad checksum then corrected frame
    send_frame(8'h01, 8'h00, 8'h10, 8'h00, 20, 280);
    drain("drain_t3a", 50);
    send_frame(8'h01, 8'h00, 8'h10, 8'h11, 20, 280);
    drain("drain_t3b", 50);
    chk("t3_ch1", {48'd0, ch_values[31:16]}, 64'h0010);

    // 4: leading garbage ignored
    send_byte(8'h00, 20, 280, 1'b0, e, acc);
    send_byte(8'hFF, 20, 280, 1'b0, e, acc);
    send_byte(8'h5A, 20, 280, 1'b0, e, acc);
    chk("t4_busy", {63'd0, busy}, 64'd0);
    send_frame(8'h03, 8'hAB, 8'hCD, 8'h65, 20, 280);
    drain("drain_t4", 50);
    chk("t4_ch3", {48'd0, ch_values[63:48]}, 64'hABCD);

    // 5: timeout mid-frame
    send_byte(8'hA5, 20, 280, 1'b0, e, acc);
    send_byte(8'h03, 2, 2, 1'b0, e, acc);
    merr++;
    e.is_err = 1'b1;
    e.cyc    = acc + 12000;
    e.vals   = pack_bank();
    e.ec     = 8'(merr);
    sb.push_back(e);
    drain("drain_timeout", 12100);
    @(negedge clk);
    chk("t5_busy", {63'd0, busy}, 64'd0);
    // out-of-range channel
    send_frame(8'h04, 8'h00, 8'h01, 8'h05, 20, 280);
    drain("drain_badch", 50);
    // saturate error counter
    for (int i = 0; i < 300; i++) begin
      send_frame(8'h00, 8'h00, 8'h00, 8'h01, 2, 2);
    end
    drain("drain_sat", 50);
    chk("t5_sat", {56'd0, err_count}, 64'd255);

    // 6: reset mid-frame discards it silently
    send_byte(8'hA5, 20, 280, 1'b0, e, acc);
    send_byte(8'h00, 20, 280, 1'b0, e, acc);
    send_byte(8'h12, 20, 280, 1'b0, e, acc);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) mbank[i] = 16'h0;
    merr = 0;
    @(negedge clk);
    chk("t6_busy", {63'd0, busy}, 64'd0);
    chk("t6_vals", ch_values, 64'd0);
    chk("t6_errc", {56'd0, err_count}, 64'd0);
    send_frame(8'h00, 8'h00, 8'h07, 8'h07, 20, 280);
    drain("drain_t6", 50);
    chk("t6_ch0", {48'd0, ch_values[15:0]}, 64'h0007);

    repeat (20) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_cmd_sequencer.md
Name: uart_cmd_sequencer

Overview:
- Consumes bytes from the serial receiver (8-bit `data` plus level-style `data_rdy`) and parses fixed 5-byte command frames.
- Each valid frame updates one of NUM_CH 16-bit setpoint registers (motor/PWM setpoints) that feed the drone actuator blocks.
- Provides header hunting, checksum validation, inter-byte timeout and error accounting, so downstream logic only ever sees complete, validated updates.

Parameters:
- NUM_CH, 4, number of 16-bit setpoint channels (2..16).
- HEADER, 8'hA5, frame start byte.
- TIMEOUT_CYCLES, 12000, max clk cycles between accepted bytes inside a frame (1 ms at 12 MHz; about 5.5 byte times at 220 clk/bit).
- CH_W, $clog2(NUM_CH), width of the channel index output.

Ports:
- clk  in  1  system clock (12 MHz).
- reset  in  1  synchronous, active-low reset; sampled on posedge clk; 0 = reset.
- rx_data  in  8  byte from the receiver; valid whenever rx_rdy is high.
- rx_rdy  in  1  receiver byte-ready level; may stay high for many cycles (a whole stop bit).
- ch_values  out  16*NUM_CH  setpoint bank; channel i occupies bits [16*i+15:16*i].
- upd_strobe  out  1  one-cycle pulse when a channel is committed.
- upd_ch  out  CH_W  index of the last committed channel; held between commits.
- frame_err  out  1  one-cycle pulse on checksum error, bad channel or timeout.
- err_count  out  8  saturating count of frame errors.
- busy  out  1  high whenever the state is not HUNT.

Behaviour:
- **Byte accept**
  - accept = rx_rdy & ~rx_rdy_q, where rx_rdy_q is rx_rdy registered.
  - rx_data is captured in the same cycle as accept.
  - rx_rdy_q resets to 1, so a level held high through reset release is NOT accepted.
  - A held rx_rdy yields exactly one accept.
- **Reset** (reset=0 at a posedge)
  - State=HUNT; all ch_values=0, upd_ch=0, upd_strobe=0, frame_err=0, err_count=0, busy=0.
  - Timeout counter, checksum and captured bytes are cleared.
  - Reset mid-frame discards the partial frame with no error pulse.
- **Frame format:** HEADER, CH, VHI, VLO, CSUM, where CSUM = CH ^ VHI ^ VLO (header excluded).
- **FSM states:** HUNT, GET_CH, GET_VHI, GET_VLO, GET_CSUM.
  - HUNT: accept of HEADER goes to GET_CH. Any other byte is ignored silently (no error, no count).
  - GET_CH / GET_VHI / GET_VLO: on accept, store the byte, XOR it into the running checksum, and advance.
  - A HEADER value in these states is treated as data, not as a resync.
  - GET_CSUM: on accept, the frame is valid iff rx_data == checksum AND CH < NUM_CH.
    - Valid: write {VHI,VLO} into channel CH, upd_ch <= CH[CH_W-1:0], upd_strobe <= 1.
    - Invalid: frame_err <= 1, err_count++ (saturates at 255), channel registers unchanged.
    - Either way, return to HUNT.
- **Latency:** the results of the final-byte accept at edge k (ch_values, upd_ch, upd_strobe, frame_err) are visible right after edge k and stay for exactly one cycle. Only ch_values and upd_ch persist.
- **Timeout**
  - The counter resets on every accept and on entry to any non-HUNT state, and counts while not in HUNT.
  - When the counter reaches TIMEOUT_CYCLES-1 with no accept: go to HUNT, frame_err pulse, err_count++.
  - An accept in the same cycle wins: no timeout, the byte is processed.
- upd_strobe and frame_err are never high in the same cycle.
- Back-to-back frames are supported: the header of the next frame may arrive on the first accept after a commit.
- The counter width is $clog2(TIMEOUT_CYCLES) bits and must not wrap.

Test Plan:
1. Hold reset=0 for 3 cycles with rx_rdy=1, then release while rx_rdy stays 1 -> all outputs 0, no byte accepted, busy=0.
2. Send A5 02 12 34 24, each rx_rdy high for 220 cycles with ~2200-cycle spacing -> ch_values[47:32]=16'h1234, upd_ch=2, upd_strobe high exactly 1 cycle after the 5th accept edge, other channels 0, err_count=0.
3. Send A5 01 00 10 00 (bad CSUM, expected 11) -> frame_err 1-cycle pulse, err_count=1, ch1 stays 0; then A5 01 00 10 11 -> ch1=16'h0010.
4. Send 00 FF 5A, then A5 03 AB CD 65 -> leading garbage ignored (err_count unchanged), ch3=16'hABCD.
5. Send A5 03, then idle 12000 cycles -> frame_err at cycle 12000 after the last accept, busy=0, err_count+1. Send A5 04 00 01 05 (CH=4 >= NUM_CH) -> frame_err, no strobe. Force 300 errors -> err_count=255.
6. Assert reset=0 for 1 cycle after A5 00 12 -> back in HUNT, no frame_err. The subsequent A5 00 00 07 07 -> ch0=16'h0007.
